// File: rtl/cu_mc_wait.sv
// Multicycle control unit with configurable fetch beats, mem_req/mem_ready wait states and timeout.
// Optional ADDI/BNE decode is enabled by defining CU_EXT_OPS_EN.
module cu_mc_wait #(
  parameter int FETCH_BEATS = 4,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   memtoreg,
  output logic                   memwrite,
  output logic                   regdst,
  output logic                   iord,
  output logic                   pcwrite,
  output logic                   branch,
  output logic                   alusrcA,
  output logic                   regwrite,
  output logic                   bne,
  output logic [1:0]             pcsrc,
  output logic [1:0]             alusrcB,
  output logic [1:0]             aluop,
  output logic [FETCH_BEATS-1:0] irwrite,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic                   bus_err
);

  localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);
  localparam logic [WW-1:0] WAIT_LIM  = WW'(MAX_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            accessing;
  logic            timeout;
`ifdef CU_EXT_OPS_EN
  logic            bne_q, bne_d;
`endif

  function automatic logic op_legal(input logic [5:0] o);
    op_legal = (o == OP_LB) || (o == OP_SB) || (o == OP_RTYPE) ||
               (o == OP_BEQ) || (o == OP_J);
`ifdef CU_EXT_OPS_EN
    op_legal = op_legal || (o == OP_ADDI) || (o == OP_BNE);
`endif
  endfunction

  assign accessing = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Timeout wins over a late mem_ready: the access is abandoned in that cycle.
  assign timeout   = (MAX_WAIT > 0) && accessing && (wait_q == WAIT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      beat_q  <= '0;
      wait_q  <= '0;
`ifdef CU_EXT_OPS_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
`ifdef CU_EXT_OPS_EN
      bne_q   <= bne_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
`ifdef CU_EXT_OPS_EN
    bne_d   = bne_q;
`endif
    if (timeout) begin
      state_d = S_FETCH;
      beat_d  = '0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DECODE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
`ifdef CU_EXT_OPS_EN
            OP_ADDI:      state_d = S_ADDIEX;
            OP_BNE:       state_d = S_BRANCH;
`endif
            default:      state_d = S_FETCH;
          endcase
`ifdef CU_EXT_OPS_EN
          bne_d = (op == OP_BNE);
`endif
        end
        S_MEMADR: state_d = (op == OP_SB) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWR:  if (mem_ready) state_d = S_FETCH;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        default:  state_d = S_FETCH;
      endcase
    end

    wait_d = wait_q;
    if (timeout || mem_ready || (state_d != state_q))
      wait_d = '0;
    else if (accessing && (wait_q != WAIT_LIM))
      wait_d = wait_q + 1'b1;
  end

  always_comb begin
    mem_req    = 1'b0;
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    alusrcA    = 1'b0;
    regwrite   = 1'b0;
    bne        = 1'b0;
    pcsrc      = 2'b00;
    alusrcB    = 2'b00;
    aluop      = 2'b00;
    irwrite    = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    if (!reset) begin
      if (timeout) begin
        bus_err = 1'b1;
      end else begin
        case (state_q)
          S_FETCH: begin
            mem_req = 1'b1;
            alusrcB = 2'b01;
            if (mem_ready) begin
              pcwrite = 1'b1;
              for (int i = 0; i < FETCH_BEATS; i++)
                irwrite[i] = (BW'(i) == beat_q);
            end
          end
          S_DECODE: begin
            alusrcA = 1'b1;
            alusrcB = 2'b11;
            if (!op_legal(op)) begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          end
          S_MEMADR: begin
            alusrcA = 1'b1;
            alusrcB = 2'b10;
          end
          S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
          end
          S_MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
          end
          S_MEMWR: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
          end
          S_EXEC: begin
            alusrcA = 1'b1;
            aluop   = 2'b10;
          end
          S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
          end
          S_BRANCH: begin
            alusrcA    = 1'b1;
            aluop      = 2'b01;
            branch     = 1'b1;
            pcsrc      = 2'b01;
            instr_done = 1'b1;
`ifdef CU_EXT_OPS_EN
            bne        = bne_q;
`endif
          end
          S_JUMP: begin
            pcwrite    = 1'b1;
            pcsrc      = 2'b10;
            instr_done = 1'b1;
          end
          S_ADDIEX: begin
            alusrcA = 1'b1;
            alusrcB = 2'b10;
          end
          S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cu_mc_wait.sv
// Bench for cu_mc_wait: per-instruction expected cycle sequences built from the control rules,
// applied with random wait states and opcodes, compared cycle by cycle.
module tb_cu_mc_wait;
  localparam int FB = 4;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic          mem_ready;
  logic          mem_req, memtoreg, memwrite, regdst, iord, pcwrite, branch, alusrcA, regwrite, bne;
  logic [1:0]    pcsrc, alusrcB, aluop;
  logic [FB-1:0] irwrite;
  logic          instr_done, illegal_op, bus_err;

  cu_mc_wait #(.FETCH_BEATS(FB), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .memtoreg(memtoreg), .memwrite(memwrite), .regdst(regdst),
    .iord(iord), .pcwrite(pcwrite), .branch(branch), .alusrcA(alusrcA),
    .regwrite(regwrite), .bne(bne), .pcsrc(pcsrc), .alusrcB(alusrcB), .aluop(aluop),
    .irwrite(irwrite), .instr_done(instr_done), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, memtoreg, memwrite, regdst, iord, pcwrite, branch, alusrcA, regwrite, bne;
    logic [1:0] pcsrc, alusrcB, aluop;
    logic [FB-1:0] irwrite;
    logic instr_done, illegal_op, bus_err;
  } ctl_t;

  typedef struct {
    ctl_t       e;
    logic       rdy;
    logic [5:0] opv;
  } cyc_t;

  cyc_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    step  = 0;
  string cur_tag = "init";

  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    return {mem_req, memtoreg, memwrite, regdst, iord, pcwrite, branch, alusrcA, regwrite, bne,
            pcsrc, alusrcB, aluop, irwrite, instr_done, illegal_op, bus_err};
  endfunction

  function automatic logic legal(input logic [5:0] o);
    logic ok;
    ok = (o == 6'h20) || (o == 6'h28) || (o == 6'h00) || (o == 6'h04) || (o == 6'h02);
`ifdef CU_EXT_OPS_EN
    ok = ok || (o == 6'h08) || (o == 6'h05);
`endif
    return ok;
  endfunction

  task automatic push(input ctl_t e, input logic rdy, input logic [5:0] o);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.opv = o;
    q.push_back(c);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 39);
    if (r < 28) return 0;
    if (r < 37) return $urandom_range(1, 4);
    if (r < 39) return MW - 1;
    return MW;
  endfunction

  // One memory access: w stalled cycles, then either completion or a bus error
  task automatic access(input ctl_t base, input ctl_t fin, input int w, output logic tmo);
    ctl_t b;
    int   n;
    tmo = (MW > 0) && (w >= MW);
    n   = tmo ? MW : w;
    for (int i = 0; i < n; i++) push(base, 1'b0, junk());
    if (tmo) begin
      b = '0;
      b.bus_err = 1'b1;
      push(b, 1'b0, junk());
    end else begin
      push(fin, 1'b1, junk());
    end
  endtask

  // Expected cycles of one instruction; wf/wm < 0 means random waits
  task automatic gen_instr(input logic [5:0] opc, input int wf, input int wm);
    ctl_t e, f;
    logic tmo;
    for (int b = 0; b < FB; b++) begin
      e = '0; e.mem_req = 1'b1; e.alusrcB = 2'b01;
      f = e;  f.pcwrite = 1'b1; f.irwrite = FB'(1) << b;
      access(e, f, (wf < 0) ? pick_wait() : wf, tmo);
      if (tmo) return;
    end
    e = '0; e.alusrcA = 1'b1; e.alusrcB = 2'b11;
    if (!legal(opc)) begin
      e.illegal_op = 1'b1; e.instr_done = 1'b1;
      push(e, rbit(), opc);
      return;
    end
    push(e, rbit(), opc);
    if (opc == 6'h20 || opc == 6'h28) begin
      e = '0; e.alusrcA = 1'b1; e.alusrcB = 2'b10;
      push(e, rbit(), opc);
      e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
      if (opc == 6'h28) begin
        e.memwrite = 1'b1;
        f = e; f.instr_done = 1'b1;
        access(e, f, (wm < 0) ? pick_wait() : wm, tmo);
      end else begin
        access(e, e, (wm < 0) ? pick_wait() : wm, tmo);
        if (!tmo) begin
          e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
          push(e, rbit(), junk());
        end
      end
    end else if (opc == 6'h00) begin
      e = '0; e.alusrcA = 1'b1; e.aluop = 2'b10;
      push(e, rbit(), junk());
      e = '0; e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
      push(e, rbit(), junk());
    end else if (opc == 6'h04 || opc == 6'h05) begin
      e = '0; e.alusrcA = 1'b1; e.aluop = 2'b01; e.branch = 1'b1; e.pcsrc = 2'b01;
      e.bne = (opc == 6'h05); e.instr_done = 1'b1;
      push(e, rbit(), junk());
    end else if (opc == 6'h02) begin
      e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.instr_done = 1'b1;
      push(e, rbit(), junk());
    end else begin
      e = '0; e.alusrcA = 1'b1; e.alusrcB = 2'b10;
      push(e, rbit(), junk());
      e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
      push(e, rbit(), junk());
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge per cycle
  task automatic run_q(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      op        = c.opv;
      #1;
      check($sformatf("%s@%0d", cur_tag, step), obs(), c.e);
      step++;
      @(negedge clk);
    end
  endtask

  task automatic directed(input string tag, input logic [5:0] opc, input int wf, input int wm);
    cur_tag = tag;
    step    = 0;
    gen_instr(opc, wf, wm);
    run_q(q.size());
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h20, 6'h28, 6'h00, 6'h04, 6'h02, 6'h08, 6'h05, 6'h3F};
    reset = 1'b1; mem_ready = 1'b1; op = 6'h00;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", obs(), '0);
    @(negedge clk);
    reset = 1'b0;

    directed("alu",       6'h00, 0, 0);
    directed("lb_wait3",  6'h20, 0, 3);
    directed("sb_tmo",    6'h28, 0, MW);
    directed("sb_edge",   6'h28, 0, MW - 1);
    directed("illegal",   6'h3F, 0, 0);
    directed("beq",       6'h04, 0, 0);
    directed("bne",       6'h05, 0, 0);
    directed("jump",      6'h02, 0, 0);
    directed("addi",      6'h08, 0, 0);
    directed("fetch_tmo", 6'h00, MW, 0);
    directed("lb_wait1",  6'h20, 1, 1);

    // Asynchronous reset while beat 1 is stalled
    cur_tag = "rst_mid";
    step = 0;
    gen_instr(6'h00, 1, 0);
    run_q(3);
    q.delete();
    #2 reset = 1'b1;
    #1 check("rst_async", obs(), '0);
    @(posedge clk);
    #1 check("rst_clocked", obs(), '0);
    @(negedge clk);
    reset = 1'b0;
    directed("after_rst", 6'h00, 0, 0);

    cur_tag = "rand";
    step = 0;
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 9);
      gen_instr((r < 8) ? ops[r] : junk(), -1, -1);
      run_q(q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
